// File: rtl/sne_evt_stream_pkg.sv
// Shared types for SNE event streams: operation codes, time types and the
// gap classes used by the timestamp regulator.
package sne_evt_stream_pkg;

    localparam int unsigned TIME_W = 24;

    typedef logic [TIME_W-1:0] time_t;

    typedef enum logic [3:0] {
        EVT_SPIKE  = 4'd0,
        EVT_TIME   = 4'd1,
        EVT_SYNC   = 4'd2,
        EVT_UPDATE = 4'd3
    } evt_op_e;

    typedef struct packed {
        evt_op_e operation;
        time_t   value;
    } timestamp_t;

    // Distance class of an incoming timestamp relative to the current time.
    typedef enum logic [2:0] {
        DUP  = 3'd0,
        NEXT = 3'd1,
        FILL = 3'd2,
        JUMP = 3'd3,
        BACK = 3'd4
    } gap_class_e;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_FILL = 1'b1
    } reg_state_e;

endpackage

// File: rtl/SNE_EVENT_STREAM.sv
// Valid/ready event stream carrying an operation code and a value field.
interface SNE_EVENT_STREAM
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned TS_W = 24
);
    logic            valid;
    logic            ready;
    evt_op_e         operation;
    logic [TS_W-1:0] value;

    modport src (output valid, output operation, output value, input ready);
    modport dst (input valid, input operation, input value, output ready);
endinterface

// File: rtl/evt_time_gap_classifier.sv
// Classifies the modulo distance between an incoming timestamp and the
// current time into DUP / NEXT / FILL / JUMP / BACK.
module evt_time_gap_classifier
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned TS_W    = 24,
    parameter int unsigned MAX_GAP = 1024
) (
    input  logic [TS_W-1:0] value,
    input  logic [TS_W-1:0] curr,
    input  logic            time_valid,
    output gap_class_e      gap_class
);
    localparam logic [TS_W-1:0] ZERO_V    = {TS_W{1'b0}};
    localparam logic [TS_W-1:0] ONE_V     = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [TS_W-1:0] MAX_GAP_V = TS_W'(MAX_GAP);

    logic [TS_W-1:0] gap_s;

    assign gap_s = value - curr;

    // Map the wrapped gap onto its class; before any time has been seen
    // everything counts as the next tick so the first stamp always goes out.
    always_comb begin
        gap_class = NEXT;
        if (!time_valid) begin
            gap_class = NEXT;
        end else if (gap_s == ZERO_V) begin
            gap_class = DUP;
        end else if (gap_s == ONE_V) begin
            gap_class = NEXT;
        end else if (gap_s <= MAX_GAP_V) begin
            gap_class = FILL;
        end else if (!gap_s[TS_W-1]) begin
            gap_class = JUMP;
        end else begin
            gap_class = BACK;
        end
    end
endmodule

// File: rtl/evt_time_regulator.sv
// Timestamp regulator: forwards events, fills short gaps between time
// events with synthetic ticks, drops repeats and flags jumps/backsteps.
module evt_time_regulator
    import sne_evt_stream_pkg::*;
#(
    parameter int unsigned TS_W    = 24,
    parameter int unsigned MAX_GAP = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fill_en_i,
    input  logic             drop_dup_i,
    input  logic             clear_i,
    SNE_EVENT_STREAM.dst     evt_time_stream_dst,
    SNE_EVENT_STREAM.src     evt_time_stream_src,
    output logic [TS_W-1:0]  curr_time_o,
    output logic             time_valid_o,
    output logic [CNT_W-1:0] ins_cnt_o,
    output logic [CNT_W-1:0] dup_cnt_o,
    output logic             jump_o,
    output logic             backstep_o,
    output logic             busy_o
);
    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    reg_state_e       state_r, state_s;
    logic [TS_W-1:0]  curr_r, target_r;
    logic             time_valid_r;
    logic [CNT_W-1:0] ins_cnt_r, dup_cnt_r;
    logic             jump_r, backstep_r;

    gap_class_e       gap_class_s;
    logic             is_time_s;
    logic             pass_hs_s;
    logic [TS_W-1:0]  tick_s;

    logic             src_valid_s;
    evt_op_e          src_op_s;
    logic [TS_W-1:0]  src_value_s;
    logic             dst_ready_s;
    logic             fwd_time_s;
    logic             drop_s;
    logic             enter_fill_s;
    logic             tick_hs_s;
    logic             jump_s;
    logic             back_s;

    evt_time_gap_classifier #(
        .TS_W    (TS_W),
        .MAX_GAP (MAX_GAP)
    ) u_classifier (
        .value      (evt_time_stream_dst.value),
        .curr       (curr_r),
        .time_valid (time_valid_r),
        .gap_class  (gap_class_s)
    );

    assign is_time_s = evt_time_stream_dst.valid && (evt_time_stream_dst.operation == EVT_TIME);
    assign pass_hs_s = evt_time_stream_dst.valid && evt_time_stream_src.ready;
    assign tick_s    = curr_r + TS_ONE;

    // Next-state and stream muxing: PASS is a combinational feed-through,
    // FILL replaces the stream with synthetic ticks while stalling the input.
    always_comb begin
        state_s      = state_r;
        src_valid_s  = evt_time_stream_dst.valid;
        src_op_s     = evt_time_stream_dst.operation;
        src_value_s  = evt_time_stream_dst.value;
        dst_ready_s  = evt_time_stream_src.ready;
        fwd_time_s   = 1'b0;
        drop_s       = 1'b0;
        enter_fill_s = 1'b0;
        tick_hs_s    = 1'b0;
        jump_s       = 1'b0;
        back_s       = 1'b0;
        case (state_r)
            ST_PASS: begin
                if (is_time_s && enable_i) begin
                    case (gap_class_s)
                        DUP: begin
                            if (drop_dup_i) begin
                                dst_ready_s = 1'b1;
                                src_valid_s = 1'b0;
                                drop_s      = 1'b1;
                            end else begin
                                fwd_time_s  = pass_hs_s;
                            end
                        end
                        FILL: begin
                            if (fill_en_i) begin
                                // Bubble cycle: hold the input, latch the target.
                                dst_ready_s  = 1'b0;
                                src_valid_s  = 1'b0;
                                enter_fill_s = 1'b1;
                                state_s      = ST_FILL;
                            end else begin
                                fwd_time_s   = pass_hs_s;
                                jump_s       = pass_hs_s;
                            end
                        end
                        JUMP: begin
                            fwd_time_s = pass_hs_s;
                            jump_s     = pass_hs_s;
                        end
                        BACK: begin
                            fwd_time_s = pass_hs_s;
                            back_s     = pass_hs_s;
                        end
                        default: begin
                            fwd_time_s = pass_hs_s;
                        end
                    endcase
                end else if (is_time_s) begin
                    fwd_time_s = pass_hs_s;
                end else begin
                    fwd_time_s = 1'b0;
                end
            end
            ST_FILL: begin
                src_valid_s = 1'b1;
                src_op_s    = EVT_TIME;
                src_value_s = tick_s;
                dst_ready_s = 1'b0;
                tick_hs_s   = evt_time_stream_src.ready;
                // Leave once the tick just emitted is the one before the target,
                // or after the in-flight tick when regulation is switched off.
                if (evt_time_stream_src.ready && (!enable_i || ((tick_s + TS_ONE) == target_r))) begin
                    state_s = ST_PASS;
                end else begin
                    state_s = ST_FILL;
                end
            end
            default: begin
                state_s = ST_PASS;
            end
        endcase
        if (clear_i) begin
            state_s = ST_PASS;
        end else begin
            state_s = state_s;
        end
    end

    assign evt_time_stream_src.valid     = src_valid_s;
    assign evt_time_stream_src.operation = src_op_s;
    assign evt_time_stream_src.value     = src_value_s;
    assign evt_time_stream_dst.ready     = dst_ready_s;

    // State, time tracking, saturating statistics and event pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_PASS;
            curr_r       <= {TS_W{1'b0}};
            target_r     <= {TS_W{1'b0}};
            time_valid_r <= 1'b0;
            ins_cnt_r    <= {CNT_W{1'b0}};
            dup_cnt_r    <= {CNT_W{1'b0}};
            jump_r       <= 1'b0;
            backstep_r   <= 1'b0;
        end else begin
            state_r <= state_s;

            if (fwd_time_s) begin
                curr_r <= evt_time_stream_dst.value;
            end else if (tick_hs_s) begin
                curr_r <= tick_s;
            end else begin
                curr_r <= curr_r;
            end

            if (enter_fill_s) begin
                target_r <= evt_time_stream_dst.value;
            end else begin
                target_r <= target_r;
            end

            if (clear_i) begin
                time_valid_r <= 1'b0;
            end else if (fwd_time_s) begin
                time_valid_r <= 1'b1;
            end else begin
                time_valid_r <= time_valid_r;
            end

            if (clear_i) begin
                ins_cnt_r <= {CNT_W{1'b0}};
            end else if (tick_hs_s && (ins_cnt_r != CNT_MAX)) begin
                ins_cnt_r <= ins_cnt_r + CNT_ONE;
            end else begin
                ins_cnt_r <= ins_cnt_r;
            end

            if (clear_i) begin
                dup_cnt_r <= {CNT_W{1'b0}};
            end else if (drop_s && (dup_cnt_r != CNT_MAX)) begin
                dup_cnt_r <= dup_cnt_r + CNT_ONE;
            end else begin
                dup_cnt_r <= dup_cnt_r;
            end

            jump_r     <= jump_s;
            backstep_r <= back_s;
        end
    end

    assign curr_time_o  = curr_r;
    assign time_valid_o = time_valid_r;
    assign ins_cnt_o    = ins_cnt_r;
    assign dup_cnt_o    = dup_cnt_r;
    assign jump_o       = jump_r;
    assign backstep_o   = backstep_r;
    assign busy_o       = (state_r == ST_FILL);
endmodule
